// File: rtl/interlaken_latency_sequencer.sv
// -----------------------------------------------------------------------------
// interlaken_latency_sequencer
//
// Campaign controller for the Interlaken driver/repeater loopback pair. It holds
// the cores in reset, waits for GT lock and RX alignment, then runs NUM_RUNS
// restart-triggered bursts. For each burst it measures the cycles from the
// restart pulse to rx_done and keeps last/min/max/sum statistics. Wait states
// are guarded by a shared timeout, and RX failures abort the campaign.
//
// Optional feature macro: LAT_PM_TICK_EN
//   defined   : pm_tick pulses for one cycle in the cycle after lat_valid
//   undefined : pm_tick is tied to 0
//
// Ports
//   init_clk       sole clock
//   clk_reset      asynchronous active-high reset (async assert, sync release)
//   start          single-cycle campaign start request (accepted in IDLE only)
//   rx_gt_locked   AND of both cores' GT lock
//   rx_aligned     AND of both cores' RX aligned
//   tx_busy        AND of both cores' tx_busy
//   rx_busy        AND of both cores' rx_busy
//   tx_done        AND of both cores' tx_done (not used for sequencing)
//   rx_done        AND of both cores' rx_done
//   rx_failed      OR of both cores' rx_failed
//   sys_reset      core reset
//   tx_rx_restart  one-cycle restart pulse to both cores
//   pm_tick        performance-monitor tick
//   busy           campaign in progress
//   done / error   sticky completion / abort flags, cleared by the next start
//   err_code       0 none, 1 lock TO, 2 align TO, 3 idle/drain TO, 4 busy TO,
//                  5 rx_done TO, 6 rx_failed
//   run_idx        index of the current/last run
//   lat_valid      one-cycle pulse when lat_last is updated
//   lat_last/min/max/sum  latency statistics
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module interlaken_latency_sequencer #(
  parameter int unsigned NUM_RUNS       = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned ACC_W          = 40,
  parameter int unsigned RST_HOLD       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
  input  logic             init_clk,
  input  logic             clk_reset,
  input  logic             start,
  input  logic             rx_gt_locked,
  input  logic             rx_aligned,
  input  logic             tx_busy,
  input  logic             rx_busy,
  input  logic             tx_done,
  input  logic             rx_done,
  input  logic             rx_failed,
  output logic             sys_reset,
  output logic             tx_rx_restart,
  output logic             pm_tick,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       err_code,
  output logic [7:0]       run_idx,
  output logic             lat_valid,
  output logic [CNT_W-1:0] lat_last,
  output logic [CNT_W-1:0] lat_min,
  output logic [CNT_W-1:0] lat_max,
  output logic [ACC_W-1:0] lat_sum
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_HOLD, S_LOCK_WAIT, S_ALIGN_WAIT, S_IDLE_WAIT, S_KICK,
    S_BUSY_WAIT, S_MEASURE, S_DRAIN, S_DONE, S_ERROR
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_LOCK_TO   = 3'd1,
    ERR_ALIGN_TO  = 3'd2,
    ERR_IDLE_TO   = 3'd3,
    ERR_BUSY_TO   = 3'd4,
    ERR_RXDONE_TO = 3'd5,
    ERR_RX_FAILED = 3'd6
  } err_e;

  // The 20-bit wait counter also times the reset hold, so RST_HOLD and
  // TIMEOUT_CYCLES must both fit in 20 bits.
  localparam logic [19:0]      HOLD_LAST = 20'(RST_HOLD - 1);
  localparam logic [19:0]      TO_LAST   = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       LAST_RUN  = 8'(NUM_RUNS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // tx_done is informational only; completion is judged on rx_done.
  logic unused_tx_done;
  assign unused_tx_done = tx_done;

  // Reset synchronizer: asserts immediately, releases two clocks later.
  logic [1:0] rst_sync_q;
  logic       rst;

  always_ff @(posedge init_clk or posedge clk_reset) begin
    if (clk_reset) rst_sync_q <= 2'b11;
    else           rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst = rst_sync_q[1];

  state_e           state_q,    state_d;
  logic [19:0]      wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] lat_cnt_q,  lat_cnt_d;
  logic [7:0]       run_idx_q,  run_idx_d;
  logic             done_q,     done_d;
  logic             error_q,    error_d;
  err_e             err_code_q, err_code_d;
  logic             lat_valid_q, lat_valid_d;
  logic [CNT_W-1:0] lat_last_q, lat_last_d;
  logic [CNT_W-1:0] lat_min_q,  lat_min_d;
  logic [CNT_W-1:0] lat_max_q,  lat_max_d;
  logic [ACC_W-1:0] lat_sum_q,  lat_sum_d;
  logic             timed_out;

  // A wait state times out after spending TIMEOUT_CYCLES cycles in it.
  assign timed_out = (wait_cnt_q == TO_LAST);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    run_idx_d   = run_idx_q;
    done_d      = done_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    lat_valid_d = 1'b0;
    lat_last_d  = lat_last_q;
    lat_min_d   = lat_min_q;
    lat_max_d   = lat_max_q;
    lat_sum_d   = lat_sum_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RST_HOLD;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          run_idx_d  = 8'd0;
          lat_last_d = '0;
          lat_min_d  = '1;
          lat_max_d  = '0;
          lat_sum_d  = '0;
        end
      end
      S_RST_HOLD: begin
        if (wait_cnt_q == HOLD_LAST) state_d = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        if (rx_gt_locked)   state_d = S_ALIGN_WAIT;
        else if (timed_out) begin state_d = S_ERROR; err_code_d = ERR_LOCK_TO; end
      end
      S_ALIGN_WAIT: begin
        if (rx_aligned)     state_d = S_IDLE_WAIT;
        else if (timed_out) begin state_d = S_ERROR; err_code_d = ERR_ALIGN_TO; end
      end
      S_IDLE_WAIT: begin
        if (!tx_busy && !rx_busy) state_d = S_KICK;
        else if (timed_out)       begin state_d = S_ERROR; err_code_d = ERR_IDLE_TO; end
      end
      S_KICK: begin
        state_d = S_BUSY_WAIT;
      end
      S_BUSY_WAIT: begin
        if (rx_failed)               begin state_d = S_ERROR; err_code_d = ERR_RX_FAILED; end
        else if (tx_busy && rx_busy) state_d = S_MEASURE;
        else if (timed_out)          begin state_d = S_ERROR; err_code_d = ERR_BUSY_TO; end
      end
      S_MEASURE: begin
        // rx_failed outranks a simultaneous rx_done: the run is discarded.
        if (rx_failed) begin
          state_d    = S_ERROR;
          err_code_d = ERR_RX_FAILED;
        end else if (rx_done) begin
          state_d     = S_DRAIN;
          lat_valid_d = 1'b1;
          lat_last_d  = lat_cnt_q;
          lat_min_d   = (lat_cnt_q < lat_min_q) ? lat_cnt_q : lat_min_q;
          lat_max_d   = (lat_cnt_q > lat_max_q) ? lat_cnt_q : lat_max_q;
          lat_sum_d   = lat_sum_q + ACC_W'(lat_cnt_q);
        end else if (timed_out) begin
          state_d    = S_ERROR;
          err_code_d = ERR_RXDONE_TO;
        end
      end
      S_DRAIN: begin
        if (rx_failed) begin
          state_d    = S_ERROR;
          err_code_d = ERR_RX_FAILED;
        end else if (!tx_busy && !rx_busy) begin
          if (run_idx_q == LAST_RUN) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_KICK;
            run_idx_d = run_idx_q + 8'd1;
          end
        end else if (timed_out) begin
          state_d    = S_ERROR;
          err_code_d = ERR_IDLE_TO;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // DONE and ERROR last one cycle, so state_d names them only on entry.
    if (state_d == S_DONE)  done_d  = 1'b1;
    if (state_d == S_ERROR) error_d = 1'b1;

    // Shared wait timer: restarts on every state change.
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (state_q inside {S_RST_HOLD, S_LOCK_WAIT, S_ALIGN_WAIT, S_IDLE_WAIT,
                                 S_BUSY_WAIT, S_MEASURE, S_DRAIN}) begin
      wait_cnt_d = wait_cnt_q + 20'd1;
    end

    // Latency reads 0 during the KICK cycle and saturates at all-ones.
    if (state_d == S_KICK) begin
      lat_cnt_d = '0;
    end else if ((state_q inside {S_KICK, S_BUSY_WAIT, S_MEASURE}) &&
                 (lat_cnt_q != CNT_MAX)) begin
      lat_cnt_d = lat_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge init_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      run_idx_q   <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      lat_valid_q <= 1'b0;
      lat_last_q  <= '0;
      lat_min_q   <= '1;
      lat_max_q   <= '0;
      lat_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      run_idx_q   <= run_idx_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      lat_valid_q <= lat_valid_d;
      lat_last_q  <= lat_last_d;
      lat_min_q   <= lat_min_d;
      lat_max_q   <= lat_max_d;
      lat_sum_q   <= lat_sum_d;
    end
  end

`ifdef LAT_PM_TICK_EN
  logic pm_tick_q;

  always_ff @(posedge init_clk or posedge rst) begin
    if (rst) pm_tick_q <= 1'b0;
    else     pm_tick_q <= lat_valid_q;
  end
  assign pm_tick = pm_tick_q;
`else
  assign pm_tick = 1'b0;
`endif

  // Moore outputs decoded straight from the state register.
  assign sys_reset     = state_q inside {S_IDLE, S_RST_HOLD, S_ERROR};
  assign tx_rx_restart = (state_q == S_KICK);
  assign busy          = !(state_q inside {S_IDLE, S_DONE, S_ERROR});

  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign run_idx   = run_idx_q;
  assign lat_valid = lat_valid_q;
  assign lat_last  = lat_last_q;
  assign lat_min   = lat_min_q;
  assign lat_max   = lat_max_q;
  assign lat_sum   = lat_sum_q;

endmodule

// File: tb/tb_interlaken_latency_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interlaken_latency_sequencer
//
// Self-checking bench. The cores are emulated per run: busy rises a few cycles
// after the restart pulse, rx_done arrives a randomly chosen number of cycles
// after it, and busy drops shortly after. The expected latency of a run is that
// chosen delay; min/max/sum come from the list of delays used in the campaign.
// Covers reset values, equal/mixed/random campaigns, lock timeout, rx_failed
// racing rx_done, and a reset in the middle of a measurement.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_interlaken_latency_sequencer;

  localparam int N_RUNS     = 3;
  localparam int CNT_W_P    = 32;
  localparam int ACC_W_P    = 40;
  localparam int RST_HOLD_P = 16;
  localparam int TO_P       = 1000;

  logic init_clk = 1'b0;
  logic clk_reset = 1'b0;
  logic start = 1'b0;
  logic rx_gt_locked = 1'b0;
  logic rx_aligned = 1'b0;
  logic tx_busy = 1'b0;
  logic rx_busy = 1'b0;
  logic tx_done = 1'b0;
  logic rx_done = 1'b0;
  logic rx_failed = 1'b0;

  logic                 sys_reset, tx_rx_restart, pm_tick, busy, done, error, lat_valid;
  logic [2:0]           err_code;
  logic [7:0]           run_idx;
  logic [CNT_W_P-1:0]   lat_last, lat_min, lat_max;
  logic [ACC_W_P-1:0]   lat_sum;

  interlaken_latency_sequencer #(
    .NUM_RUNS(N_RUNS), .CNT_W(CNT_W_P), .ACC_W(ACC_W_P),
    .RST_HOLD(RST_HOLD_P), .TIMEOUT_CYCLES(TO_P)
  ) dut (
    .init_clk(init_clk), .clk_reset(clk_reset), .start(start),
    .rx_gt_locked(rx_gt_locked), .rx_aligned(rx_aligned),
    .tx_busy(tx_busy), .rx_busy(rx_busy), .tx_done(tx_done),
    .rx_done(rx_done), .rx_failed(rx_failed),
    .sys_reset(sys_reset), .tx_rx_restart(tx_rx_restart), .pm_tick(pm_tick),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .run_idx(run_idx), .lat_valid(lat_valid), .lat_last(lat_last),
    .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum)
  );

  always #5 init_clk = ~init_clk;

  int total = 0;
  int bad   = 0;
  int delays [N_RUNS];
  logic [CNT_W_P-1:0] all_ones = '1;

  // Free-running monitor, sampled on the falling edge.
  int   lv_cnt = 0, rs_cnt = 0, rs_pair = 0, pm_bad = 0;
  logic prev_rs = 1'b0, prev_lv = 1'b0;
  logic exp_pm;

  always @(negedge init_clk) begin
`ifdef LAT_PM_TICK_EN
    exp_pm = prev_lv;
`else
    exp_pm = 1'b0;
`endif
    if (lat_valid)                 lv_cnt  <= lv_cnt + 1;
    if (tx_rx_restart)             rs_cnt  <= rs_cnt + 1;
    if (tx_rx_restart && prev_rs)  rs_pair <= rs_pair + 1;
    if (pm_tick !== exp_pm)        pm_bad  <= pm_bad + 1;
    prev_rs <= tx_rx_restart;
    prev_lv <= lat_valid;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Outputs are observed 1 ns after the active edge; inputs set here are
  // sampled at the following edge.
  task automatic step();
    @(posedge init_clk);
    #1;
  endtask

  task automatic start_and_hold(input string tag);
    int hold;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_on_start"}, busy, 1);
    hold = 0;
    while (sys_reset && hold < 200) begin
      hold++;
      step();
    end
    check({tag, "_rst_hold_len"}, hold, RST_HOLD_P);
  endtask

  task automatic bring_up(input string tag, input int lock_dly, input int align_dly);
    rx_gt_locked = 1'b0;
    rx_aligned   = 1'b0;
    start_and_hold(tag);
    repeat (lock_dly) step();
    rx_gt_locked = 1'b1;
    repeat (align_dly) step();
    rx_aligned = 1'b1;
  endtask

  task automatic wait_restart(input string tag);
    int n;
    n = 0;
    while (!tx_rx_restart && n < 3000) begin
      step();
      n++;
    end
    check({tag, "_restart_seen"}, tx_rx_restart, 1);
  endtask

  // One run, cycle 0 being the restart cycle; rx_done is high in cycle d.
  task automatic do_run(input string tag, input int idx, input int d);
    int b, r;
    b = $urandom_range(5, 1);
    r = $urandom_range(10, 2);
    wait_restart(tag);
    check({tag, "_run_idx"}, run_idx, idx);
    for (int c = 0; c <= d + r; c++) begin
      if (c == b) begin tx_busy = 1'b1; rx_busy = 1'b1; end
      rx_done = (c == d);
      tx_done = (c == d);
      if (c == d + 1) begin
        check({tag, "_lat_valid"}, lat_valid, 1);
        check({tag, "_lat_last"}, lat_last, d);
      end
      if (c == d + r) begin tx_busy = 1'b0; rx_busy = 1'b0; end
      step();
    end
    rx_done = 1'b0;
    tx_done = 1'b0;
  endtask

  task automatic run_campaign(input string tag, input int lock_dly, input int align_dly);
    int     lv0, rs0, mn, mx;
    longint sm;
    lv0 = lv_cnt;
    rs0 = rs_cnt;
    bring_up(tag, lock_dly, align_dly);
    for (int i = 0; i < N_RUNS; i++) do_run(tag, i, delays[i]);
    mn = delays[0];
    mx = delays[0];
    sm = 0;
    for (int i = 0; i < N_RUNS; i++) begin
      if (delays[i] < mn) mn = delays[i];
      if (delays[i] > mx) mx = delays[i];
      sm += delays[i];
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_run_idx_end"}, run_idx, N_RUNS - 1);
    check({tag, "_lat_min"}, lat_min, mn);
    check({tag, "_lat_max"}, lat_max, mx);
    check({tag, "_lat_sum"}, lat_sum, sm);
    check({tag, "_lat_valid_cnt"}, lv_cnt - lv0, N_RUNS);
    check({tag, "_restart_cnt"}, rs_cnt - rs0, N_RUNS);
    step();
    check({tag, "_done_sticky"}, done, 1);
    check({tag, "_idle_sys_reset"}, sys_reset, 1);
  endtask

  initial begin
    int n, lv0;

    // Power-on reset.
    #3 clk_reset = 1'b1;
    repeat (3) step();
    check("rst_sys_reset", sys_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_run_idx", run_idx, 0);
    check("rst_restart", tx_rx_restart, 0);
    check("rst_lat_valid", lat_valid, 0);
    check("rst_lat_last", lat_last, 0);
    check("rst_lat_min", lat_min, all_ones);
    check("rst_lat_max", lat_max, 0);
    check("rst_lat_sum", lat_sum, 0);
    check("rst_pm_tick", pm_tick, 0);
    clk_reset = 1'b0;
    repeat (5) step();
    check("idle_sys_reset", sys_reset, 1);

    // Equal latencies, then a mixed set.
    delays = '{200, 200, 200};
    run_campaign("c_eq", 14, 20);
    delays = '{100, 300, 200};
    run_campaign("c_mix", 10, 10);

    // Random campaigns.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N_RUNS; i++) delays[i] = $urandom_range(400, 20);
      run_campaign("c_rnd", $urandom_range(40, 0), $urandom_range(40, 0));
    end

    // rx_failed together with rx_done in run 0: abort, no stats update.
    lv0 = lv_cnt;
    bring_up("c_fail", 3, 3);
    wait_restart("c_fail");
    for (int c = 0; c < 40; c++) begin
      if (c == 2) begin tx_busy = 1'b1; rx_busy = 1'b1; end
      step();
    end
    rx_done = 1'b1;
    rx_failed = 1'b1;
    step();
    check("fail_error", error, 1);
    check("fail_err_code", err_code, 6);
    check("fail_sys_reset", sys_reset, 1);
    check("fail_busy", busy, 0);
    rx_done = 1'b0;
    rx_failed = 1'b0;
    tx_busy = 1'b0;
    rx_busy = 1'b0;
    step();
    check("fail_error_sticky", error, 1);
    check("fail_done", done, 0);
    check("fail_lat_valid_cnt", lv_cnt - lv0, 0);
    check("fail_lat_last", lat_last, 0);
    check("fail_lat_min", lat_min, all_ones);
    check("fail_lat_max", lat_max, 0);
    check("fail_lat_sum", lat_sum, 0);

    // Lock never arrives: timeout after exactly TO_P cycles in LOCK_WAIT.
    rx_gt_locked = 1'b0;
    rx_aligned = 1'b0;
    start_and_hold("c_lock");
    n = 0;
    while (!error && n < 5000) begin
      step();
      n++;
    end
    check("lock_to_cycles", n, TO_P);
    check("lock_to_err_code", err_code, 1);
    check("lock_to_sys_reset", sys_reset, 1);
    check("lock_to_busy", busy, 0);
    repeat (3) step();
    check("lock_to_error_sticky", error, 1);

    // Reset in the middle of run 1's measurement.
    delays[0] = 150;
    bring_up("c_abort", 5, 5);
    do_run("c_abort", 0, delays[0]);
    wait_restart("c_abort1");
    for (int c = 0; c < 60; c++) begin
      if (c == 2) begin tx_busy = 1'b1; rx_busy = 1'b1; end
      step();
    end
    clk_reset = 1'b1;
    #1;
    check("abort_sys_reset", sys_reset, 1);
    check("abort_busy", busy, 0);
    check("abort_run_idx", run_idx, 0);
    check("abort_lat_last", lat_last, 0);
    check("abort_lat_min", lat_min, all_ones);
    check("abort_lat_sum", lat_sum, 0);
    tx_busy = 1'b0;
    rx_busy = 1'b0;
    repeat (2) step();
    clk_reset = 1'b0;
    repeat (5) step();
    for (int i = 0; i < N_RUNS; i++) delays[i] = $urandom_range(400, 20);
    run_campaign("c_clean", 8, 8);

    check("restart_back_to_back", rs_pair, 0);
    check("pm_tick_mismatch_cycles", pm_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/interlaken_latency_sequencer.md
Name: interlaken_latency_sequencer

Overview:
Campaign controller for the Interlaken driver/repeater loopback pair. It holds the cores in reset, then waits for GT lock and RX alignment. It then runs NUM_RUNS restart-triggered packet bursts and measures the cycle latency from each restart pulse to rx_done. It keeps last/min/max/sum statistics and flags timeouts and RX failures. It replaces the hand-written message-flag sequencing in the FPGA top and drives the shared sys_reset and lbus_tx_rx_restart_in nets.

Parameters:
NUM_RUNS, 4, measurement runs per campaign (1..255)
CNT_W, 32, latency counter / statistic width
ACC_W, 40, lat_sum accumulator width
RST_HOLD, 16, cycles sys_reset is held after start (>=1)
TIMEOUT_CYCLES, 1048575, max cycles spent in any wait state before error

Ports:
init_clk  in  1  sole clock
clk_reset  in  1  asynchronous active-high reset
start  in  1  single-cycle campaign start request
rx_gt_locked  in  1  AND of both cores' GT lock
rx_aligned  in  1  AND of both cores' RX aligned
tx_busy  in  1  AND of both cores' tx_busy
rx_busy  in  1  AND of both cores' rx_busy
tx_done  in  1  AND of both cores' tx_done
rx_done  in  1  AND of both cores' rx_done
rx_failed  in  1  OR of both cores' rx_failed
sys_reset  out  1  core reset
tx_rx_restart  out  1  one-cycle restart pulse to both cores
pm_tick  out  1  performance-monitor tick (see Optional Feature)
busy  out  1  campaign in progress
done  out  1  campaign completed, sticky until next start
error  out  1  campaign aborted, sticky until next start
err_code  out  3  0 none, 1 lock TO, 2 align TO, 3 idle TO, 4 busy TO, 5 rx_done TO, 6 rx_failed
run_idx  out  8  index of current/last run
lat_valid  out  1  one-cycle pulse when lat_last updated
lat_last  out  CNT_W  latency of last run
lat_min  out  CNT_W  minimum latency
lat_max  out  CNT_W  maximum latency
lat_sum  out  ACC_W  sum of latencies

Behaviour:
- Reset (async assert, sync release): state IDLE, sys_reset=1, all other outputs 0, lat_min=all-ones.
- States: IDLE, RST_HOLD, LOCK_WAIT, ALIGN_WAIT, IDLE_WAIT, KICK, BUSY_WAIT, MEASURE, DRAIN, DONE, ERROR.
- IDLE: sys_reset=1. On start: clear done, error, err_code, run_idx and stats (lat_min=all-ones). Set busy=1 and go to RST_HOLD.
- RST_HOLD: sys_reset=1 for exactly RST_HOLD cycles, then 0 from LOCK_WAIT onward.
- LOCK_WAIT -> ALIGN_WAIT on rx_gt_locked. ALIGN_WAIT -> IDLE_WAIT on rx_aligned.
- IDLE_WAIT -> KICK when tx_busy=0 and rx_busy=0.
- KICK: one cycle. tx_rx_restart=1, latency counter cleared to 0. Then BUSY_WAIT.
- BUSY_WAIT -> MEASURE when tx_busy=1 and rx_busy=1. tx_done is ignored.
- Latency counter increments every cycle after KICK and saturates at 2^CNT_W-1. It runs through BUSY_WAIT and MEASURE.
- MEASURE: on the first cycle rx_done=1, take lat = counter value in that cycle (KICK cycle = 0). Next cycle: lat_last=lat, lat_valid=1, lat_min=min, lat_max=max, lat_sum+=lat (wraps modulo 2^ACC_W). Then DRAIN.
- DRAIN: wait for tx_busy=0 and rx_busy=0. If run_idx==NUM_RUNS-1 go DONE, else run_idx+1 and go KICK.
- DONE: busy=0, done=1. Go to IDLE on the next cycle, keeping done sticky.
- Timeout: one 20-bit counter, cleared on every state change. It runs in LOCK_WAIT, ALIGN_WAIT, IDLE_WAIT, BUSY_WAIT, MEASURE and DRAIN. When it reaches TIMEOUT_CYCLES, go ERROR with the matching err_code (DRAIN uses code 3).
- rx_failed=1 in BUSY_WAIT, MEASURE or DRAIN -> ERROR, code 6. If rx_failed and rx_done are both 1 in the same cycle, rx_failed wins and no stats update occurs.
- ERROR: busy=0, error=1, sys_reset=1. Go to IDLE next cycle, keeping error sticky.
- start is ignored while busy=1.
- clk_reset mid-campaign aborts immediately to reset values. No partial statistics are retained.
- tx_rx_restart is never asserted outside KICK and is never high on two consecutive cycles.

Optional Feature:
LAT_PM_TICK_EN
- Defined: pm_tick pulses for one cycle in the cycle after lat_valid, so the cores' PM counters snapshot per run.
- Undefined: pm_tick is constantly 0 and the related logic is removed.

Test Plan:
- NUM_RUNS=2, RST_HOLD=16. start; lock at +30, align at +50; model busy 3 cycles after restart and rx_done 200 cycles after restart -> sys_reset high 16 cycles, 2 restart pulses, lat_last=200 both runs, min=max=200, sum=400, done=1, err_code=0.
- NUM_RUNS=3 with rx_done delays 100/300/200 -> lat_min=100, lat_max=300, lat_sum=600, 3 lat_valid pulses, run_idx=2.
- rx_gt_locked never asserted, TIMEOUT_CYCLES=1000 -> error=1, err_code=1, exactly 1000 cycles after entering LOCK_WAIT, sys_reset=1.
- rx_failed and rx_done asserted together in run 0 -> err_code=6, lat_valid never pulses, stats unchanged.
- clk_reset asserted mid-MEASURE, then start again -> immediate reset values (sys_reset=1, busy=0), then a clean campaign with correct stats.
- With LAT_PM_TICK_EN defined, NUM_RUNS=2 -> 2 pm_tick pulses, each one cycle after lat_valid. Without it, pm_tick stays 0.
